// File: rtl/wir_loader.sv
//-----------------------------------------------------------------------------
// wir_loader
//
// Loads one SIZE-bit instruction into a serially accessed Wrapper Instruction
// Register (WIR). A load runs CAPTURE -> SHIFT (SIZE cycles, LSB first) ->
// UPDATE -> DONE. While the new instruction is shifted in, the previous WIR
// content returned on wir_so is collected into readback.
//
// Build option:
//   WIR_LOADER_READBACK_EN  defined   : CAPTURE state and readback collection
//                                       are present.
//                           undefined : CAPTURE is skipped, wir_capture and
//                                       readback are tied to 0, wir_so unused.
//
// Ports:
//   CLK          in   clock, rising edge active
//   WRSTN        in   asynchronous active-low reset
//   start        in   request one load (sampled in IDLE only)
//   abort        in   cancel a load in CAPTURE/SHIFT
//   opcode       in   [SIZE] instruction, latched when start is accepted
//   busy         out  high whenever the FSM is not IDLE
//   done         out  one-cycle pulse after a completed load
//   wir_si       out  serial data to the WIR (0 outside SHIFT)
//   wir_capture  out  WIR capture strobe
//   wir_shift    out  WIR shift enable
//   wir_update   out  WIR update strobe
//   wir_so       in   serial data from the WIR
//   readback     out  [SIZE] previous WIR content collected during SHIFT
//-----------------------------------------------------------------------------
module wir_loader #(
    parameter int SIZE = 12
) (
    input  logic            CLK,
    input  logic            WRSTN,
    input  logic            start,
    input  logic            abort,
    input  logic [SIZE-1:0] opcode,
    output logic            busy,
    output logic            done,
    output logic            wir_si,
    output logic            wir_capture,
    output logic            wir_shift,
    output logic            wir_update,
    input  logic            wir_so,
    output logic [SIZE-1:0] readback
);

    localparam int CNT_W = $clog2(SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SHIFT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [SIZE-1:0]   r_sr;
    logic              r_busy;
    logic              r_done;
    logic              r_si;
    logic              r_shift;
    logic              r_update;
    logic              w_last;
    logic              w_si_next;

    always_comb begin
        w_next    = r_state;
        w_si_next = 1'b0;
        w_last    = (r_cnt == CNT_W'(SIZE - 1));
        case (r_state)
            S_IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
`ifdef WIR_LOADER_READBACK_EN
                    w_next = S_CAPTURE;
`else
                    w_next = S_SHIFT;
`endif
                end
            end
            S_CAPTURE: w_next = abort ? S_IDLE : S_SHIFT;
            S_SHIFT: begin
                if (abort)       w_next = S_IDLE;
                else if (w_last) w_next = S_UPDATE;
            end
            S_UPDATE: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase

        // wir_si is registered, so the bit for the coming shift cycle is
        // chosen here: bit 0 on entry, then the next bit of the shifting
        // register while SHIFT continues.
        if (w_next == S_SHIFT) begin
            case (r_state)
                S_SHIFT:   w_si_next = r_sr[1];
                S_CAPTURE: w_si_next = r_sr[0];
                default:   w_si_next = opcode[0];
            endcase
        end
    end

    always_ff @(posedge CLK or negedge WRSTN) begin
        if (!WRSTN) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sr     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_si     <= 1'b0;
            r_shift  <= 1'b0;
            r_update <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_busy   <= (w_next != S_IDLE);
            r_done   <= (w_next == S_DONE);
            r_si     <= w_si_next;
            r_shift  <= (w_next == S_SHIFT);
            r_update <= (w_next == S_UPDATE);

            if (r_state == S_IDLE && w_next != S_IDLE)
                r_sr <= opcode;
            else if (r_state == S_SHIFT && w_next != S_IDLE)
                r_sr <= r_sr >> 1;

            // counter restarts on every entry into SHIFT, so it never wraps
            if (r_state == S_SHIFT && w_next == S_SHIFT)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign wir_si     = r_si;
    assign wir_shift  = r_shift;
    assign wir_update = r_update;

`ifdef WIR_LOADER_READBACK_EN
    logic            r_capture;
    logic [SIZE-1:0] r_readback;

    always_ff @(posedge CLK or negedge WRSTN) begin
        if (!WRSTN) begin
            r_capture  <= 1'b0;
            r_readback <= '0;
        end else begin
            r_capture <= (w_next == S_CAPTURE);
            // the edge closing shift cycle k stores bit k-1; an aborting
            // edge stores nothing, leaving unsampled bits untouched
            if (r_state == S_SHIFT && !abort)
                r_readback[r_cnt] <= wir_so;
        end
    end

    assign wir_capture = r_capture;
    assign readback    = r_readback;
`else
    logic w_unused;

    assign w_unused    = wir_so;
    assign wir_capture = 1'b0;
    assign readback    = '0;
`endif

endmodule

// File: doc/wir_loader.md
WIR_LOADER -- requirements
Module: wir_loader

Interface
REQ-001 SHALL have parameter: SIZE, default 12, WIR instruction length in bits (SIZE >= 2).
REQ-002 SHALL have ports, one per line:
- CLK  input  1  single clock; all state changes on its rising edge.
- WRSTN  input  1  asynchronous active-low reset.
- start  input  1  request to load one instruction; sampled only in IDLE.
- abort  input  1  cancel an in-progress load.
- opcode  input  SIZE  instruction to load; latched on the accepting edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on successful completion.
- wir_si  output  1  serial data to the WIR.
- wir_capture  output  1  WIR capture strobe.
- wir_shift  output  1  WIR shift enable.
- wir_update  output  1  WIR update strobe.
- wir_so  input  1  serial data returned from the WIR.
- readback  output  SIZE  previous WIR content shifted out during the load.

Function
REQ-003 SHALL implement FSM states IDLE, CAPTURE, SHIFT, UPDATE, DONE; every output SHALL be registered.
REQ-004 IDLE: start=1 at an edge SHALL latch opcode into an internal shift register and move to CAPTURE; start=0 SHALL stay in IDLE.
REQ-005 CAPTURE: wir_capture=1 for exactly one cycle, then SHIFT.
REQ-006 SHIFT: wir_shift=1 for exactly SIZE consecutive cycles; a SIZE-range bit counter SHALL count them and SHALL not wrap inside one load.
REQ-007 SHIFT: wir_si SHALL carry opcode bit k-1 in shift cycle k (k=1..SIZE), LSB first, stable for the whole cycle.
REQ-008 SHIFT: wir_so sampled at the edge ending shift cycle k SHALL be stored in readback[k-1].
REQ-009 After shift cycle SIZE, the FSM SHALL enter UPDATE: wir_update=1 for exactly one cycle, then DONE.
REQ-010 DONE: done=1 for exactly one cycle, then IDLE.
REQ-011 Latency: if start is accepted at edge 0, CAPTURE is cycle 1, SHIFT is cycles 2..SIZE+1, UPDATE is cycle SIZE+2, and DONE is cycle SIZE+3; busy=1 during cycles 1..SIZE+3.
REQ-012 wir_capture, wir_shift and wir_update SHALL be mutually exclusive in every cycle; wir_si=0 whenever wir_shift=0.
REQ-013 start while busy=1 SHALL be ignored, with no queueing.
REQ-014 start and abort high together in IDLE: abort wins and the FSM stays in IDLE.
REQ-015 abort=1 in CAPTURE or SHIFT SHALL return the FSM to IDLE at that edge:
- no UPDATE and no done.
- readback holds the partial bits; unsampled bits are unchanged.
REQ-016 abort in UPDATE or DONE SHALL be ignored; completion proceeds.
REQ-017 readback SHALL only change during SHIFT, and SHALL hold its value between loads.

Reset
REQ-018 WRSTN=0 SHALL immediately, independent of CLK, force:
- state IDLE.
- busy, done, wir_si, wir_capture, wir_shift, wir_update = 0.
- readback, latched opcode and bit counter = 0.
REQ-019 Reset asserted mid-load SHALL abandon the load with no wir_update pulse; after reset release the first edge SHALL be treated as IDLE.

Configuration
REQ-020 Macro WIR_LOADER_READBACK_EN: when defined, behaviour is as REQ-003..REQ-017.
REQ-021 When WIR_LOADER_READBACK_EN is undefined:
- CAPTURE is skipped; IDLE goes straight to SHIFT.
- wir_capture is constant 0; readback is constant 0; wir_so is unused.
- latency becomes SHIFT cycles 1..SIZE, UPDATE SIZE+1, DONE SIZE+2.

Verification
REQ-022 Reset: WRSTN=0 in the middle of a CLK high phase -> all outputs 0 immediately, without waiting for an edge.
REQ-023 Normal load: SIZE=12, opcode=12'b010010010010, start pulsed at edge 0, WIR preloaded with 12'hA5C -> expected response:
- wir_si sequence 0,1,0,0,1,0,0,1,0,0,1,0 in cycles 2..13.
- wir_update=1 in cycle 14; done=1 in cycle 15.
- WIR holds 12'h492 and readback=12'hA5C.
REQ-024 Back-to-back: a second start with opcode 12'hFFF while busy -> ignored; the same start reissued in the done cycle+1 -> accepted, and the WIR ends at 12'hFFF.
REQ-025 Abort: abort=1 in shift cycle 6 -> next state IDLE, no wir_update, no done, and WIR decoded outputs unchanged.
REQ-026 Simultaneous: start=1 and abort=1 in IDLE -> busy stays 0; abort=1 in the UPDATE cycle -> done still pulses.
REQ-027 Macro undefined: same stimulus as REQ-023 -> wir_capture is never 1, wir_update=1 in cycle 13, done=1 in cycle 14, readback=0.
